// File: rtl/clkdiv_2_3_ctrl_if.sv
// rtl/clkdiv_2_3_ctrl_if.sv - configuration and prescaler-facing signals of the pulse-swallow controller
interface clkdiv_2_3_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] s;
    logic             sel;
    logic             out;
    logic             tick;
    logic             running;

    modport master (
        output en, m, s,
        input  sel, out, tick, running
    );

    modport slave (
        input  en, m, s,
        output sel, out, tick, running
    );
endinterface

// File: rtl/clkdiv_2_3_ctrl.sv
// rtl/clkdiv_2_3_ctrl.sv - pulse-swallow controller for a 2/3 prescaler, N = 2*m + s
module clkdiv_2_3_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    clkdiv_2_3_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] m_n;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] s_n;
    logic             start;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH:0]   half_n;
    logic             sel_n;
    logic             out_n;
    logic             tick_n;
    logic             running_n;

    assign start  = bus.en && (bus.m >= TWO);
    assign s_eff  = (bus.s > bus.m) ? bus.m : bus.s;
    // One extra bit so m = 2^WIDTH-1 rounds up without wrapping.
    assign half_n = ({1'b0, m_n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            m_r   <= '0;
            s_r   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            m_r   <= m_n;
            s_r   <= s_n;
        end
    end

    // Config is only sampled at a period boundary, so retuning never cuts a period short.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        m_n     = m_r;
        s_n     = s_r;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    m_n     = bus.m;
                    s_n     = s_eff;
                end
            end
            RUN: begin
                if (cnt != m_r - ONE) begin
                    cnt_n = cnt + ONE;
                end else if (start) begin
                    cnt_n = '0;
                    m_n   = bus.m;
                    s_n   = s_eff;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode the next-state count so they line up with the registered cnt.
    always_comb begin
        sel_n     = 1'b0;
        out_n     = 1'b0;
        tick_n    = 1'b0;
        running_n = 1'b0;
        if (state_n == RUN) begin
            sel_n     = (cnt_n < s_n);
            out_n     = ({1'b0, cnt_n} < half_n);
            tick_n    = (cnt_n == '0);
            running_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sel     <= 1'b0;
            bus.out     <= 1'b0;
            bus.tick    <= 1'b0;
            bus.running <= 1'b0;
        end else begin
            bus.sel     <= sel_n;
            bus.out     <= out_n;
            bus.tick    <= tick_n;
            bus.running <= running_n;
        end
    end
endmodule

// File: tb/tb_clkdiv_2_3_ctrl.sv
// tb/tb_clkdiv_2_3_ctrl.sv - self-checking bench for clkdiv_2_3_ctrl
module tb_clkdiv_2_3_ctrl;
    typedef struct {
        string        name;
        logic         en;
        logic [7:0]   m;
        logic [7:0]   s;
        logic         run;
        logic [255:0] sel_pat;
        logic [255:0] out_pat;
        int           n_fast;
    } vec_t;

    typedef struct {
        string name;
        logic  sel;
        logic  out;
        logic  tick;
        logic  running;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[10];

    clkdiv_2_3_ctrl_if #(.WIDTH(8)) bus ();

    clkdiv_2_3_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] mask(input int k);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input string name, input logic en, input int m, input int s,
                                input logic run, input int sel_ones, input int out_ones, input int n_fast);
        vec_t v;
        v.name    = name;
        v.en      = en;
        v.m       = 8'(m);
        v.s       = 8'(s);
        v.run     = run;
        v.sel_pat = mask(sel_ones);
        v.out_pat = mask(out_ones);
        v.n_fast  = n_fast;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        check_bit({e.name, " sel"},     bus.sel,     e.sel);
        check_bit({e.name, " out"},     bus.out,     e.out);
        check_bit({e.name, " tick"},    bus.tick,    e.tick);
        check_bit({e.name, " running"}, bus.running, e.running);
    endtask

    task automatic expect_now(input string name, input logic sel, input logic out,
                              input logic tick, input logic running);
        sb.push_back('{name, sel, out, tick, running});
        compare_head();
    endtask

    // Expectation queued before the edge, compared at the following falling edge.
    task automatic step(input string name, input logic sel, input logic out,
                        input logic tick, input logic running);
        sb.push_back('{name, sel, out, tick, running});
        @(negedge clk);
        compare_head();
    endtask

    task automatic reset_and_set(input logic en, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        rst    = 1'b1;
        bus.en = en;
        bus.m  = m;
        bus.s  = s;
        @(negedge clk);
        expect_now("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int c;
        int mm;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.m    = '0;
        bus.s    = '0;

        vecs[0] = mk("m5_s2",     1'b1,   5,   2, 1'b1,   2,   3,  12);
        vecs[1] = mk("m4_s7clmp", 1'b1,   4,   7, 1'b1,   4,   2,  12);
        vecs[2] = mk("m4_s0",     1'b1,   4,   0, 1'b1,   0,   2,   8);
        vecs[3] = mk("m2_s1",     1'b1,   2,   1, 1'b1,   1,   1,   5);
        vecs[4] = mk("m3_s3",     1'b1,   3,   3, 1'b1,   3,   2,   9);
        vecs[5] = mk("m6_s1",     1'b1,   6,   1, 1'b1,   1,   3,  13);
        vecs[6] = mk("m255_s200", 1'b1, 255, 200, 1'b1, 200, 128, 710);
        vecs[7] = mk("m1_idle",   1'b1,   1,   1, 1'b0,   0,   0,   0);
        vecs[8] = mk("m0_idle",   1'b1,   0,   0, 1'b0,   0,   0,   0);
        vecs[9] = mk("en0_idle",  1'b0,   5,   2, 1'b0,   0,   0,   0);

        repeat (2) @(negedge clk);
        expect_now("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 10; v++) begin
            reset_and_set(vecs[v].en, vecs[v].m, vecs[v].s);
            if (!vecs[v].run) begin
                for (int k = 0; k < 4; k++) step(vecs[v].name, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                mm  = int'(vecs[v].m);
                acc = 0;
                for (int k = 0; k < 2 * mm + 1; k++) begin
                    c = k % mm;
                    step(vecs[v].name, vecs[v].sel_pat[c], vecs[v].out_pat[c], c == 0, 1'b1);
                    // Prescaler model: each clk period spans 3 fast cycles when sel, else 2.
                    if (bus.tick) begin
                        if (k > 0) check_int({vecs[v].name, " N"}, acc, vecs[v].n_fast);
                        acc = 0;
                    end
                    acc += bus.sel ? 3 : 2;
                end
            end
        end

        // Retune mid-period: the running 6-cycle period completes unchanged.
        reset_and_set(1'b1, 8'd6, 8'd1);
        step("retune c0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("retune c1", 1'b0, 1'b1, 1'b0, 1'b1);
        step("retune c2", 1'b0, 1'b1, 1'b0, 1'b1);
        bus.m = 8'd3;
        bus.s = 8'd3;
        step("retune c3", 1'b0, 1'b0, 1'b0, 1'b1);
        step("retune c4", 1'b0, 1'b0, 1'b0, 1'b1);
        step("retune c5", 1'b0, 1'b0, 1'b0, 1'b1);
        step("retune n0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("retune n1", 1'b1, 1'b1, 1'b0, 1'b1);
        step("retune n2", 1'b1, 1'b0, 1'b0, 1'b1);
        step("retune n3", 1'b1, 1'b1, 1'b1, 1'b1);

        // en dropped mid-period: finish the period, then idle; re-enable restarts with tick.
        reset_and_set(1'b1, 8'd5, 8'd2);
        step("endrop c0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("endrop c1", 1'b1, 1'b1, 1'b0, 1'b1);
        bus.en = 1'b0;
        step("endrop c2", 1'b0, 1'b1, 1'b0, 1'b1);
        step("endrop c3", 1'b0, 1'b0, 1'b0, 1'b1);
        step("endrop c4", 1'b0, 1'b0, 1'b0, 1'b1);
        step("endrop idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("endrop idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.en = 1'b1;
        step("endrop restart", 1'b1, 1'b1, 1'b1, 1'b1);

        // m below 2 holds IDLE until a valid m arrives.
        reset_and_set(1'b1, 8'd1, 8'd1);
        step("m1 idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("m1 idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.m = 8'd2;
        step("m2 c0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("m2 c1", 1'b0, 1'b0, 1'b0, 1'b1);
        step("m2 c0b", 1'b1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset between edges clears outputs without a clock edge.
        reset_and_set(1'b1, 8'd5, 8'd2);
        step("arst c0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("arst c1", 1'b1, 1'b1, 1'b0, 1'b1);
        step("arst c2", 1'b0, 1'b1, 1'b0, 1'b1);
        step("arst c3", 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_now("arst immediate", 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step("arst r0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("arst r1", 1'b1, 1'b1, 1'b0, 1'b1);
        step("arst r2", 1'b0, 1'b1, 1'b0, 1'b1);
        step("arst r3", 1'b0, 1'b0, 1'b0, 1'b1);
        step("arst r4", 1'b0, 1'b0, 1'b0, 1'b1);
        step("arst r5", 1'b1, 1'b1, 1'b1, 1'b1);

        check_int("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clkdiv_2_3_ctrl.md
Name: clkdiv_2_3_ctrl

Overview:
Pulse-swallow controller for the 2/3 dual-modulus prescaler. It is clocked by the prescaler output and drives the prescaler's division-select line, so that prescaler plus controller divide the fast input by N = 2*M + S. It also produces a near-50% divided output and a period-start strobe. It sits directly after the prescaler in programmable clock-synthesis chains.

Parameters:
WIDTH, 8, width of M/S inputs and of the internal cycle counter.

Ports:
clk  input  1  prescaler output clock; all logic on posedge.
rst  input  1  asynchronous reset, active-high.
en  input  1  run request; sampled only at period boundaries.
m  input  WIDTH  prescaler cycles per output period; values below 2 mean "disabled".
s  input  WIDTH  number of divide-by-3 cycles per period; clamped to m.
sel  output  1  to prescaler select (1 = divide by 3); registered.
out  output  1  divided clock; registered, glitch-free.
tick  output  1  one-clk pulse, high during the first prescaler cycle of each period.
running  output  1  high while in RUN.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, m_r=0, s_r=0, sel=0, out=0, tick=0, running=0.
- States: IDLE and RUN. All outputs are registered and update only on posedge clk.
- Effective config: m_eff = m; s_eff = (s > m) ? m : s.
- Start condition: en=1 and m>=2.
- IDLE:
  - If the start condition holds: go to RUN, m_r<=m_eff, s_r<=s_eff, cnt<=0.
  - Otherwise stay in IDLE with all outputs 0.
- RUN, cnt < m_r-1: cnt<=cnt+1.
- RUN, cnt == m_r-1 (period boundary):
  - If the start condition holds: cnt<=0 and reload m_r/s_r from the current inputs (new config applies from the next period).
  - Else: go to IDLE, cnt<=0, outputs 0.
  - m/s/en changes mid-period are ignored until the boundary, so retuning never truncates or extends a period.
- Output decode, computed from the next-state values and registered with cnt (RUN only):
  - sel = (cnt < s_r)
  - out = (cnt < ceil(m_r/2))
  - tick = (cnt == 0)
  - running = 1
- In IDLE all of sel, out, tick and running are 0.
- Resulting division of the prescaler input: 2*m_r + s_r. Range is 4 .. 3*(2^WIDTH-1).
- First period after start:
  - tick=1, out=1 and sel=(0<s_r) in the first clk cycle after the start edge.
  - No partial period is ever emitted.
- Latency: the sel value registered for count index i governs prescaler period i. The prescaler samples its select once per period at its own decision point, so sel is stable across that period.
- Width rules: cnt is WIDTH bits; m_r-1 is computed in WIDTH bits; ceil(m_r/2) = (m_r+1)>>1 is computed in WIDTH+1 bits so m=2^WIDTH-1 does not overflow.
- s==m: every cycle is divide-by-3, N=3m. s==0: N=2m.
- rst asserted mid-period forces the reset values at once. After release the block restarts from IDLE; the first period start is the first posedge with the start condition true.

Decomposition:
- No shared package is needed.
- State encoding (IDLE/RUN) is local parameters inside the module.
- No sub-module. A separate top-level pairing of clkdiv_2_3 and clkdiv_2_3_ctrl (clkdiv_dm) is a later, distinct block and not part of this one.

Test Plan:
1. Reset held, then released with en=1, m=5, s=2. Expected, cnt 0..4 per period: sel 1,1,0,0,0; out 1,1,1,0,0; tick 1,0,0,0,0. Repeats every 5 clk. Paired with a prescaler model: 12 fast cycles per out period.
2. m=4, s=7 (clamp). Expected: sel constant 1, out 1,1,0,0, N=12. Then m=4, s=0: sel constant 0, N=8.
3. Running m=6, s=1; change to m=3, s=3 at cnt=2. Expected: the current 6-cycle period completes unchanged; the next period is 3 cycles with sel 1,1,1 and out 1,1,0.
4. en dropped at cnt=1 of m=5. Expected: period finishes (cnt 2,3,4), then all outputs 0 and running=0. Re-raising en gives tick=1 one clk later.
5. m=1 or m=0 with en=1. Expected: stays in IDLE, all outputs 0. Switching to m=2, s=1 gives sel 1,0; out 1,0; N=5.
6. Async rst pulse between clk edges at cnt=3. Expected: outputs 0 immediately, without waiting for a clk edge. Restart yields a full period beginning with tick=1 and cnt=0.
